// File: rtl/btn_debounce_if.sv
// rtl/btn_debounce_if.sv - raw button pins and conditioned button outputs of btn_debounce
interface btn_debounce_if #(
  parameter int NBTN = 3
);
  logic [NBTN-1:0] btn;
  logic [NBTN-1:0] btn_level;
  logic [NBTN-1:0] btn_press;
  logic [NBTN-1:0] btn_release;
  logic [NBTN-1:0] btn_long;

  modport master (
    output btn,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

  modport slave (
    input  btn,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button 2-flop synchronizer and debounce FSM with press/release strobes
// Long-press strobe is built only when BTN_DEBOUNCE_LONG_PRESS_EN is defined.
module btn_debounce #(
  parameter int NBTN            = 3,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CTR_W           = 18,
  parameter int LONG_CYCLES     = 25000000,
  parameter int LONG_W          = 25
) (
  input logic           i_clk,
  input logic           i_rst_n,
  btn_debounce_if.slave bus
);
  localparam logic [1:0] ST_UP      = 2'd0;
  localparam logic [1:0] ST_DB_DOWN = 2'd1;
  localparam logic [1:0] ST_DOWN    = 2'd2;
  localparam logic [1:0] ST_DB_UP   = 2'd3;

  localparam logic [CTR_W-1:0] CNT_LAST = CTR_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || (64'd1 << CTR_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_ctr
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2 and fit in CTR_W bits");
  end
  if ((64'd1 << LONG_W) <= 64'(LONG_CYCLES)) begin : g_bad_long
    $error("btn_debounce: LONG_CYCLES must fit in LONG_W bits");
  end

  logic [NBTN-1:0] s1;
  logic [NBTN-1:0] s2;
  logic [NBTN-1:0] level_v;
  logic [NBTN-1:0] press_v;
  logic [NBTN-1:0] release_v;
  logic [NBTN-1:0] long_v;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.btn;
      s2 <= s1;
    end
  end

  for (genvar g = 0; g < NBTN; g++) begin : g_ch
    logic [1:0]       state;
    logic [CTR_W-1:0] cnt;
    logic             level;
    logic             press;
    logic             rel;
    logic             enter_down;
    logic             enter_up;

    // The debounce window completes on this edge with the input still at the new value.
    assign enter_down = (state == ST_DB_DOWN) && s2[g] && (cnt == CNT_LAST);
    assign enter_up   = (state == ST_DB_UP) && !s2[g] && (cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        state <= ST_UP;
        cnt   <= '0;
        level <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
      end else begin
        press <= 1'b0;
        rel   <= 1'b0;
        case (state)
          ST_UP: begin
            if (s2[g]) begin
              state <= ST_DB_DOWN;
              cnt   <= '0;
            end
          end
          ST_DB_DOWN: begin
            if (!s2[g]) begin
              state <= ST_UP;
            end else if (enter_down) begin
              state <= ST_DOWN;
              level <= 1'b1;
              press <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_DOWN: begin
            if (!s2[g]) begin
              state <= ST_DB_UP;
              cnt   <= '0;
            end
          end
          ST_DB_UP: begin
            if (s2[g]) begin
              state <= ST_DOWN;
            end else if (enter_up) begin
              state <= ST_UP;
              level <= 1'b0;
              rel   <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= ST_UP;
        endcase
      end
    end

    assign level_v[g]   = level;
    assign press_v[g]   = press;
    assign release_v[g] = rel;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0] hold;
    logic              long_q;

    // Hold counter parks one past LONG_LAST so the strobe fires once per press.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        hold   <= '0;
        long_q <= 1'b0;
      end else begin
        long_q <= 1'b0;
        if (enter_up || state == ST_UP || state == ST_DB_DOWN) begin
          hold <= '0;
        end else if (hold == LONG_LAST) begin
          hold   <= hold + 1'b1;
          long_q <= 1'b1;
        end else if (hold < LONG_LAST) begin
          hold <= hold + 1'b1;
        end
      end
    end

    assign long_v[g] = long_q;
`else
    assign long_v[g] = 1'b0;
`endif
  end

  assign bus.btn_level   = level_v;
  assign bus.btn_press   = press_v;
  assign bus.btn_release = release_v;
  assign bus.btn_long    = long_v;
endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - scoreboard bench for btn_debounce against a run-length reference model
`timescale 1ns/1ps
module tb_btn_debounce;
  localparam int NBTN   = 3;
  localparam int DEB    = 4;
  localparam int CTR_W  = 3;
  localparam int LONG   = 10;
  localparam int LONG_W = 4;

  typedef struct packed {
    logic [NBTN-1:0] level;
    logic [NBTN-1:0] press;
    logic [NBTN-1:0] rel;
    logic [NBTN-1:0] lng;
  } exp_t;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   long_seen = 0;
  int   long_cyc  = -1;

  exp_t exp_q[$];

  btn_debounce_if #(.NBTN(NBTN)) bus ();

  btn_debounce #(
    .NBTN(NBTN), .DEBOUNCE_CYCLES(DEB), .CTR_W(CTR_W),
    .LONG_CYCLES(LONG), .LONG_W(LONG_W)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Reference model: a level flips once DEB+1 consecutive synchronized samples disagree with it.
  logic [NBTN-1:0] m_s1 = '0;
  logic [NBTN-1:0] m_s2 = '0;
  logic [NBTN-1:0] m_level = '0;
  int              m_run[NBTN];
  int              m_age[NBTN];

  always @(posedge i_clk) begin
    exp_t e;
    e = '0;
    if (!i_rst_n) begin
      m_s1 = '0;
      m_s2 = '0;
      m_level = '0;
      for (int c = 0; c < NBTN; c++) begin
        m_run[c] = 0;
        m_age[c] = 0;
      end
    end else begin
      for (int c = 0; c < NBTN; c++) begin
        if (m_s2[c] != m_level[c]) m_run[c] = m_run[c] + 1;
        else m_run[c] = 0;
        if (m_run[c] == DEB + 1) begin
          m_run[c] = 0;
          if (m_level[c]) e.rel[c] = 1'b1;
          else e.press[c] = 1'b1;
          m_level[c] = ~m_level[c];
          m_age[c] = 0;
        end else if (m_level[c] && m_age[c] < LONG) begin
          m_age[c] = m_age[c] + 1;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
          if (m_age[c] == LONG) e.lng[c] = 1'b1;
`endif
        end
      end
      m_s2 = m_s1;
      m_s1 = bus.btn;
    end
    e.level = m_level;
    exp_q.push_back(e);
  end

  // Monitor: every edge presents a full output set, compared on the following falling edge.
  always @(negedge i_clk) begin
    exp_t e;
    exp_t got;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL scoreboard cyc=%0d got lvl=%b prs=%b rel=%b lng=%b want lvl=%b prs=%b rel=%b lng=%b",
                 cyc, got.level, got.press, got.rel, got.lng, e.level, e.press, e.rel, e.lng);
      end
      checks++;
      if ((bus.btn_press & bus.btn_release) !== '0) begin
        errors++;
        $display("FAIL press_release_overlap cyc=%0d got %b want 0", cyc, bus.btn_press & bus.btn_release);
      end
      if (bus.btn_long[0] === 1'b1) begin
        long_seen++;
        long_cyc = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Waits for a strobe on channel ch; returns the edge number it followed, or -1 on timeout.
  task automatic wait_strobe(input int ch, input bit is_press, output int at);
    at = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge i_clk);
      if ((is_press ? bus.btn_press[ch] : bus.btn_release[ch]) === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int c1;
    int at;
    int base;

    // Reset held with all buttons pressed
    bus.btn = 3'b111;
    i_rst_n = 1'b0;
    step(5);
    i_rst_n = 1'b1;
    step(3);
    bus.btn = '0;
    step(15);

    // Clean press on channel 0
    bus.btn[0] = 1'b1;
    c1 = cyc + 1;
    wait_strobe(0, 1'b1, at);
    check_int("press0_latency", at, c1 + DEB + 2);
    step(3);
    check_int("press0_level_held", int'(bus.btn_level[0]), 1);

    // Bounce on channel 1, then a clean hold
    for (int i = 0; i < 5; i++) begin
      bus.btn[1] = 1'b1;
      step(2);
      bus.btn[1] = 1'b0;
      step(2);
    end
    check_int("bounce1_level", int'(bus.btn_level[1]), 0);
    bus.btn[1] = 1'b1;
    c1 = cyc + 1;
    wait_strobe(1, 1'b1, at);
    check_int("press1_after_bounce", at, c1 + DEB + 2);

    // Simultaneous press and release on channels 0 and 2
    bus.btn = '0;
    step(15);
    bus.btn[0] = 1'b1;
    bus.btn[2] = 1'b1;
    c1 = cyc + 1;
    wait_strobe(0, 1'b1, at);
    check_int("simul_press0_latency", at, c1 + DEB + 2);
    check_int("simul_press2_same_cycle", int'(bus.btn_press[2]), 1);
    step(3);
    bus.btn[0] = 1'b0;
    bus.btn[2] = 1'b0;
    c1 = cyc + 1;
    wait_strobe(0, 1'b0, at);
    check_int("simul_release0_latency", at, c1 + DEB + 2);
    check_int("simul_release2_same_cycle", int'(bus.btn_release[2]), 1);
    step(12);

    // Reset part-way through a debounce window, button held throughout
    bus.btn[0] = 1'b1;
    step(5);
    i_rst_n = 1'b0;
    step(2);
    i_rst_n = 1'b1;
    c1 = cyc + 1;
    wait_strobe(0, 1'b1, at);
    check_int("press_after_reset_latency", at, c1 + DEB + 2);

    // Long hold on channel 0
    bus.btn = '0;
    step(15);
    long_seen = 0;
    long_cyc = -1;
    bus.btn[0] = 1'b1;
    wait_strobe(0, 1'b1, at);
    base = at;
    step(40);
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    check_int("long_pulse_count", long_seen, 1);
    check_int("long_pulse_timing", long_cyc, base + LONG);
`else
    check_int("long_pulse_count", long_seen, 0);
`endif
    bus.btn = '0;
    step(15);

    // Randomized hold lengths per channel, with occasional resets
    begin
      int remain[NBTN];
      for (int c = 0; c < NBTN; c++) remain[c] = 1;
      for (int n = 0; n < 4000; n++) begin
        for (int c = 0; c < NBTN; c++) begin
          remain[c] = remain[c] - 1;
          if (remain[c] <= 0) begin
            bus.btn[c] = ~bus.btn[c];
            remain[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30))
                                                     : int'($urandom_range(1, 8));
          end
        end
        i_rst_n = ($urandom_range(0, 399) != 0);
        step(1);
      end
    end
    i_rst_n = 1'b1;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
